data_mem_alt_ram: RTL and testbench
===================================

# data_mem_alt_ram

Parameterised simple dual-port synchronous RAM with one write port and one registered read port, sharing a single clock. It is the frame-buffer's alternative line/word store, sitting between the pixel writer and the display reader. Write and read strobes are active-low. The read data output is a register that the asynchronous reset clears.

## Interface
- DATA_WIDTH, default 16: width of every word and of both data buses.
- ADDR_WIDTH, default 3: address width; depth is 2**ADDR_WIDTH words.
- WRITE_FIRST, default 0: sets same-cycle same-address behaviour. 0 returns the old word. 1 returns the newly written word.
- clk  in  1  single clock; all sampling is on the rising edge.
- reset  in  1  asynchronous, active-high reset; it acts on the rd_data register only.
- wr_en  in  1  write strobe, active-low (0 = write).
- rd_en  in  1  read strobe, active-low (0 = read).
- wr_addr  in  ADDR_WIDTH  write address.
- rd_addr  in  ADDR_WIDTH  read address.
- wr_data  in  DATA_WIDTH  write data.
- rd_data  out  DATA_WIDTH  registered read data.

## Operation
- Storage: an array of 2**ADDR_WIDTH words of DATA_WIDTH bits. Contents are not initialised, and reset does not clear them.
- Write: on a rising clk edge with wr_en=0, mem[wr_addr] <= wr_data. With wr_en=1, memory is unchanged.
- Read: on a rising clk edge with rd_en=0, rd_data <= mem[rd_addr]. With rd_en=1, rd_data holds its previous value.
- Reset: while reset=1, rd_data is forced to 0 immediately, without waiting for clk.
  - Writes are still accepted during reset.
  - Reads are suppressed during reset; rd_data stays 0.
- Release of reset: normal operation resumes at the first rising edge after reset falls.
- Same-cycle read and write to the same address:
  - WRITE_FIRST=0: rd_data takes the pre-write contents.
  - WRITE_FIRST=1: rd_data takes wr_data through a bypass.
- Different addresses in the same cycle never interact.
- Addresses wrap naturally at 2**ADDR_WIDTH. Every address value is valid; there is no out-of-range case.
- Reading a never-written location returns X in simulation. The bench must not check it.

## Timing
- Write latency: 1 cycle. The data is readable by a read issued on the next edge after the write edge.
- Read latency: 1 cycle. rd_data is valid just after the rising edge that sampled rd_en=0 and rd_addr.
- No handshake, no backpressure and no busy state. Every cycle can perform one read and one write.
- Reset output values: rd_data = 0. That is the only output.
- Reset asserted mid-read: rd_data goes to 0 asynchronously. The in-flight read is discarded.

## Structure
- No shared package is needed. Width and depth constants stay as module parameters; the depth is derived as 1 << ADDR_WIDTH.
- Split into two pieces:
  - One sub-module, data_mem_alt_array, holding the plain inferable RAM array: write port plus unregistered read-address port, no reset.
  - The top level, which adds the rd_data register, the active-low enable decode, the asynchronous reset and the optional WRITE_FIRST bypass mux.
- Keeping reset out of the array preserves block-RAM inference.

## Test plan
- Reset check: hold reset=1 with rd_en=0 for 2 cycles -> rd_data=0 throughout. Assert reset mid-cycle after a valid read -> rd_data drops to 0 before the next edge.
- Write/read sequence:
  - With wr_en=0, write addr 2=0x0002, addr 3=0x0003 and addr 4=0x0004 on successive edges.
  - Then set wr_en=1, rd_en=0 and step rd_addr 2, 3, 4.
  - Required: rd_data reads 0x0002, 0x0003, 0x0004, each one edge after its address.
- Read hold: read addr 3 (0x0003), then raise rd_en=1 and change rd_addr to 4 -> rd_data stays 0x0003.
- Write disable: with wr_en=1, drive wr_addr=2 and wr_data=0xFFFF for 3 edges; then read addr 2 -> 0x0002.
- Collision: addr 1 holds 0x0001; write 0x00AA to addr 1 while reading addr 1 in the same cycle.
  - WRITE_FIRST=0: rd_data=0x0001.
  - WRITE_FIRST=1: rd_data=0x00AA.
  - Both settings: the next read returns 0x00AA.
- Wrap/full depth: write 0x0010+i to every address 0..7, then read all eight. Also drive the address that follows 7 (i.e. 0) -> 0x0010.

Source files
------------

// File: rtl/data_mem_alt_array.sv
// Plain inferable RAM array: one write port, one unregistered read-address port.
// Deliberately reset-free so synthesis can map it onto block RAM.
module data_mem_alt_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_wr_addr] <= i_wr_data;
    end

    // Combinational read: the consumer registers it, so it sees pre-write contents.
    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/data_mem_alt_ram.sv
// Simple dual-port RAM for the frame-buffer alternative store: active-low strobes,
// registered read data with async clear, optional write-first bypass.
module data_mem_alt_ram #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 3,
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic                  w_we;
    logic                  w_re;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_mem_q;
    logic [DATA_WIDTH-1:0] w_rd_next;
    logic [DATA_WIDTH-1:0] r_rd_data;

    assign w_we = ~wr_en;
    assign w_re = ~rd_en;

    data_mem_alt_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_mem_q)
    );

    // Bypass only matters on a same-address collision; otherwise the array word is current.
    assign w_bypass  = WRITE_FIRST && w_we && (wr_addr == rd_addr);
    assign w_rd_next = w_bypass ? wr_data : w_mem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rd_data <= '0;
        else if (w_re)
            r_rd_data <= w_rd_next;
    end

    assign rd_data = r_rd_data;
endmodule

// File: tb/tb_data_mem_alt_ram.sv
// Bench for data_mem_alt_ram: read-first and write-first instances share stimulus,
// directed scenarios plus randomized traffic checked against an array model.
module tb_data_mem_alt_ram;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b1;
    logic        rd_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd0, rd1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain word array with written-flags, expected output per instance.
    logic [15:0] mdl_mem [8];
    bit          mdl_vld [8];
    logic [15:0] exp_rd  [2];
    bit          exp_ok  [2];

    always #5 clk = ~clk;

    data_mem_alt_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .WRITE_FIRST(1'b0)) u_rf (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data), .rd_data(rd0)
    );

    data_mem_alt_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .WRITE_FIRST(1'b1)) u_wf (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data), .rd_data(rd1)
    );

    // Advance one edge and apply the behavioural rules to the model, then settle.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                exp_rd[k] = 16'h0000;
                exp_ok[k] = 1'b1;
            end else if (!rd_en) begin
                if (k == 1 && !wr_en && wr_addr == rd_addr) begin
                    exp_rd[k] = wr_data;
                    exp_ok[k] = 1'b1;
                end else begin
                    exp_rd[k] = mdl_mem[rd_addr];
                    exp_ok[k] = mdl_vld[rd_addr];
                end
            end
        end
        if (!wr_en) begin
            mdl_mem[wr_addr] = wr_data;
            mdl_vld[wr_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b1; rd_addr = 3'd0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if ({rd0, rd1} !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %h/%h want 0000/0000", c, rd0, rd1);
            end
        end
        reset = 1'b0;
        rd_en = 1'b1;
    endtask

    task automatic test_write_read();
        logic [15:0] want;
        rd_en = 1'b1; wr_en = 1'b0;
        for (int a = 2; a <= 4; a++) begin
            wr_addr = 3'(a); wr_data = 16'(a);
            tick();
        end
        wr_en = 1'b1; rd_en = 1'b0;
        for (int a = 2; a <= 4; a++) begin
            rd_addr = 3'(a);
            tick();
            want = 16'(a);
            n_tests++;
            if (rd0 !== want || rd1 !== want) begin
                n_fail++;
                $display("FAIL write_read addr%0d: got %h/%h want %h", a, rd0, rd1, want);
            end
        end
    endtask

    task automatic test_read_hold();
        rd_en = 1'b0; rd_addr = 3'd3;
        tick();
        rd_en = 1'b1; rd_addr = 3'd4;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (rd0 !== 16'h0003 || rd1 !== 16'h0003) begin
                n_fail++;
                $display("FAIL read_hold cyc%0d: got %h/%h want 0003", c, rd0, rd1);
            end
        end
    endtask

    task automatic test_write_disable();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF; rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0; rd_addr = 3'd2;
        tick();
        n_tests++;
        if (rd0 !== 16'h0002 || rd1 !== 16'h0002) begin
            n_fail++;
            $display("FAIL write_disable: got %h/%h want 0002", rd0, rd1);
        end
    endtask

    task automatic test_collision();
        rd_en = 1'b1; wr_en = 1'b0; wr_addr = 3'd1; wr_data = 16'h0001;
        tick();
        wr_data = 16'h00AA; rd_addr = 3'd1; rd_en = 1'b0;
        tick();
        n_tests++;
        if (rd0 !== 16'h0001) begin
            n_fail++;
            $display("FAIL collision_read_first: got %h want 0001", rd0);
        end
        n_tests++;
        if (rd1 !== 16'h00AA) begin
            n_fail++;
            $display("FAIL collision_write_first: got %h want 00aa", rd1);
        end
        wr_en = 1'b1;
        tick();
        n_tests++;
        if (rd0 !== 16'h00AA || rd1 !== 16'h00AA) begin
            n_fail++;
            $display("FAIL collision_after: got %h/%h want 00aa", rd0, rd1);
        end
    endtask

    task automatic test_wrap();
        logic [2:0]  a;
        logic [15:0] want;
        rd_en = 1'b1; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 3'(i); wr_data = 16'h0010 + 16'(i);
            tick();
        end
        wr_en = 1'b1; rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
            want = 16'h0010 + 16'(i);
            n_tests++;
            if (rd0 !== want || rd1 !== want) begin
                n_fail++;
                $display("FAIL wrap_read addr%0d: got %h/%h want %h", i, rd0, rd1, want);
            end
        end
        a = 3'd7;
        rd_addr = a + 3'd1;
        tick();
        n_tests++;
        if (rd0 !== 16'h0010 || rd1 !== 16'h0010) begin
            n_fail++;
            $display("FAIL wrap_next: got %h/%h want 0010", rd0, rd1);
        end
    endtask

    task automatic test_reset_mid_read();
        rd_en = 1'b0; rd_addr = 3'd5; wr_en = 1'b1;
        tick();
        n_tests++;
        if (rd0 !== 16'h0015 || rd1 !== 16'h0015) begin
            n_fail++;
            $display("FAIL pre_reset_read: got %h/%h want 0015", rd0, rd1);
        end
        #2 reset = 1'b1;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        #1;
        n_tests++;
        if ({rd0, rd1} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%h want 0000/0000", rd0, rd1);
        end
        wr_en = 1'b0; wr_addr = 3'd6; wr_data = 16'h1234;
        tick();
        n_tests++;
        if ({rd0, rd1} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read_suppress: got %h/%h want 0000/0000", rd0, rd1);
        end
        reset = 1'b0; wr_en = 1'b1; rd_addr = 3'd6;
        tick();
        n_tests++;
        if (rd0 !== 16'h1234 || rd1 !== 16'h1234) begin
            n_fail++;
            $display("FAIL write_during_reset: got %h/%h want 1234", rd0, rd1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            reset   = ($urandom_range(0, 39) == 0);
            wr_en   = $urandom_range(0, 1) == 1;
            rd_en   = $urandom_range(0, 3) == 0;
            wr_addr = 3'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            wr_data = 16'($urandom);
            tick();
            if (exp_ok[0]) begin
                n_tests++;
                if (rd0 !== exp_rd[0]) begin
                    n_fail++;
                    $display("FAIL random_rf it%0d: got %h want %h", n, rd0, exp_rd[0]);
                end
            end
            if (exp_ok[1]) begin
                n_tests++;
                if (rd1 !== exp_rd[1]) begin
                    n_fail++;
                    $display("FAIL random_wf it%0d: got %h want %h", n, rd1, exp_rd[1]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            mdl_mem[i] = 16'h0;
            mdl_vld[i] = 1'b0;
        end
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        exp_ok[0] = 1'b1;  exp_ok[1] = 1'b1;
        #2;
        test_reset();
        test_write_read();
        test_read_hold();
        test_write_disable();
        test_collision();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
